// File: rtl/uart_operand_rx.sv
// uart_operand_rx: 8N1 UART receiver and WRITE-packet parser (BA CD, 16 operand bytes, checksum).
// Optional macro PKT_TIMEOUT_EN adds an inter-byte gap timeout that drops partial packets.
module uart_operand_rx #(
    parameter int CLKS_PER_BIT = 10416
`ifdef PKT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CLKS = 20 * CLKS_PER_BIT
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx_i,
    output logic [127:0] operands_o,
    output logic         operands_valid_o,
    output logic         chk_err_o,
    output logic         frame_err_o,
    output logic         busy_o
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        PK_HDR0,
        PK_HDR1,
        PK_PAYLOAD,
        PK_CHK
    } pk_state_t;

    logic          rx_meta_q;
    logic          rx_sync_q;
    rx_state_t     rx_state_q;
    logic [CW-1:0] clk_cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    rx_data_q;
    logic          byte_stb_q;
    logic          frame_err_q;

    pk_state_t     pk_state_q;
    logic [3:0]    pay_cnt_q;
    logic [127:0]  sr_q;
    logic [127:0]  operands_q;
    logic          valid_q;
    logic          chk_err_q;
    logic [7:0]    chk_d;

    // Byte receiver; the synchronizer idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            rx_data_q   <= '0;
            byte_stb_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx_i;
            rx_sync_q   <= rx_meta_q;
            byte_stb_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    clk_cnt_q <= '0;
                    bit_idx_q <= '0;
                    if (!rx_sync_q) begin
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (clk_cnt_q == HALF_LAST) begin
                        clk_cnt_q  <= '0;
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        rx_data_q <= {rx_sync_q, rx_data_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q   <= '0;
                        byte_stb_q  <= rx_sync_q;
                        frame_err_q <= !rx_sync_q;
                        rx_state_q  <= RX_IDLE;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

`ifdef PKT_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [GW-1:0] GAP_LIMIT = GW'(TIMEOUT_CLKS);

    logic [GW-1:0] gap_cnt_q;
    logic          gap_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_cnt_q <= '0;
        end else if (byte_stb_q || pk_state_q == PK_HDR0) begin
            gap_cnt_q <= '0;
        end else if (gap_cnt_q != GAP_LIMIT) begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
        end
    end

    assign gap_hit = (gap_cnt_q == GAP_LIMIT);
`endif

    // Only the low bytes of A and B survive the mod-256 sum of 0xBACD + A + B.
    assign chk_d = 8'hCD + sr_q[71:64] + sr_q[7:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pk_state_q <= PK_HDR0;
            pay_cnt_q  <= '0;
            sr_q       <= '0;
            operands_q <= '0;
            valid_q    <= 1'b0;
            chk_err_q  <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            chk_err_q <= 1'b0;
            if (frame_err_q) begin
                pk_state_q <= PK_HDR0;
            end else if (byte_stb_q) begin
                case (pk_state_q)
                    PK_HDR0: begin
                        if (rx_data_q == 8'hBA) begin
                            pk_state_q <= PK_HDR1;
                        end
                    end
                    PK_HDR1: begin
                        pay_cnt_q <= '0;
                        if (rx_data_q == 8'hCD) begin
                            pk_state_q <= PK_PAYLOAD;
                        end else if (rx_data_q != 8'hBA) begin
                            pk_state_q <= PK_HDR0;
                        end
                    end
                    PK_PAYLOAD: begin
                        sr_q      <= {sr_q[119:0], rx_data_q};
                        pay_cnt_q <= pay_cnt_q + 4'd1;
                        if (pay_cnt_q == 4'd15) begin
                            pk_state_q <= PK_CHK;
                        end
                    end
                    PK_CHK: begin
                        if (rx_data_q == chk_d) begin
                            operands_q <= sr_q;
                            valid_q    <= 1'b1;
                        end else begin
                            chk_err_q <= 1'b1;
                        end
                        pk_state_q <= PK_HDR0;
                    end
                    default: pk_state_q <= PK_HDR0;
                endcase
            end
`ifdef PKT_TIMEOUT_EN
            else if (gap_hit) begin
                pk_state_q <= PK_HDR0;
            end
`endif
        end
    end

    assign operands_o       = operands_q;
    assign operands_valid_o = valid_q;
    assign chk_err_o        = chk_err_q;
    assign frame_err_o      = frame_err_q;
    assign busy_o           = (pk_state_q != PK_HDR0);

endmodule

// File: tb/tb_uart_operand_rx.sv
// Bench for uart_operand_rx: table of packets plus hand-written corner sequences,
// with a strobe scoreboard fed at stimulus time and drained by a strobe monitor.
module tb_uart_operand_rx;

    localparam int CPB = 16;
    localparam int EV_VALID = 0;
    localparam int EV_CHK   = 1;
    localparam int EV_FRAME = 2;

    logic         clk;
    logic         rst_n;
    logic         rx;
    logic [127:0] operands_o;
    logic         operands_valid_o;
    logic         chk_err_o;
    logic         frame_err_o;
    logic         busy_o;

    uart_operand_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rx_i             (rx),
        .operands_o       (operands_o),
        .operands_valid_o (operands_valid_o),
        .chk_err_o        (chk_err_o),
        .frame_err_o      (frame_err_o),
        .busy_o           (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           kind;
        logic [127:0] ops;
    } ev_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [7:0]  chk;
        int          bad_idx;
        int          exp_kind;
    } vec_t;

    ev_t          sb_q[$];
    int           tests_run;
    int           tests_failed;
    bit           in_reset;
    logic [127:0] last_good;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [127:0] ops);
        ev_t e;
        e.kind = kind;
        e.ops  = ops;
        sb_q.push_back(e);
        if (kind == EV_VALID) last_good = ops;
    endtask

    task automatic take_event(input int kind);
        ev_t e;
        if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_strobe: got kind %0d, required no strobe", kind);
        end else begin
            e = sb_q.pop_front();
            check("strobe_kind", 128'(kind), 128'(e.kind));
            if (kind == EV_VALID) check("operands_on_valid", operands_o, e.ops);
        end
    endtask

    task automatic monitor();
        logic [127:0] prev_ops;
        int nstb;
        prev_ops = '0;
        forever begin
            @(negedge clk);
            if (in_reset) begin
                prev_ops = operands_o;
                continue;
            end
            nstb = int'(operands_valid_o) + int'(chk_err_o) + int'(frame_err_o);
            if (nstb != 0) check("strobe_onehot", 128'(nstb), 128'(1));
            if (operands_o !== prev_ops) check("ops_change_only_on_valid", 128'(operands_valid_o), 128'(1));
            if (operands_valid_o) take_event(EV_VALID);
            if (chk_err_o)        take_event(EV_CHK);
            if (frame_err_o)      take_event(EV_FRAME);
            prev_ops = operands_o;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_bit);
        @(negedge clk) rx = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) rx = b[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk) rx = stop_bit;
        repeat (CPB - 1) @(negedge clk);
        if (!stop_bit) begin
            @(negedge clk) rx = 1'b1;
            repeat (2 * CPB) @(negedge clk);
        end
    endtask

    task automatic send_payload(input logic [127:0] ops, input int first, input int last);
        for (int i = first; i <= last; i++) send_byte(ops[127 - 8 * i -: 8], 1'b1);
    endtask

    task automatic send_header();
        send_byte(8'hBA, 1'b1);
        send_byte(8'hCD, 1'b1);
        check("busy_after_header", 128'(busy_o), 128'(1));
    endtask

    task automatic idle_bits(input int n);
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 8 * CPB && sb_q.size() != 0; i++) @(negedge clk);
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_missing_strobe: %0d strobes pending, required 0", name, sb_q.size());
            sb_q.delete();
        end
        idle_bits(2);
        check({name, "_busy_idle"}, 128'(busy_o), 128'(0));
        check({name, "_operands_hold"}, operands_o, last_good);
    endtask

    task automatic pulse_reset();
        in_reset = 1'b1;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        last_good = '0;
        repeat (2) @(negedge clk);
        in_reset = 1'b0;
    endtask

    initial begin
        vec_t vecs[7];
        logic [127:0] ops;

        tests_run    = 0;
        tests_failed = 0;
        last_good    = '0;
        in_reset     = 1'b1;
        rst_n        = 1'b0;
        rx           = 1'b1;

        vecs[0] = '{64'h0000000000000001, 64'h0000000000000002, 8'hD0, -1, EV_VALID};
        vecs[1] = '{64'h0000000000000001, 64'h0000000000000002, 8'hD1, -1, EV_CHK};
        vecs[2] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 8'hCC, -1, EV_VALID};
        vecs[3] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 8'hCC,  4, EV_FRAME};
        vecs[4] = '{64'hFFFFFFFFFFFFFFFF, 64'h0000000000000001, 8'hCD, -1, EV_VALID};
        vecs[5] = '{64'hDEADBEEFCAFEF00D, 64'h0000000000000033, 8'h0D, -1, EV_VALID};
        vecs[6] = '{64'hDEADBEEFCAFEF00D, 64'h0000000000000033, 8'h0E, -1, EV_CHK};

        fork
            monitor();
        join_none

        repeat (5) @(negedge clk);
        check("reset_operands",  operands_o, 128'h0);
        check("reset_valid",     128'(operands_valid_o), 128'(0));
        check("reset_chk_err",   128'(chk_err_o), 128'(0));
        check("reset_frame_err", 128'(frame_err_o), 128'(0));
        check("reset_busy",      128'(busy_o), 128'(0));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        in_reset = 1'b0;

        foreach (vecs[v]) begin
            ops = {vecs[v].a, vecs[v].b};
            $display("[TB] vec %0d a=%h b=%h chk=%h bad_idx=%0d kind=%0d",
                     v, vecs[v].a, vecs[v].b, vecs[v].chk, vecs[v].bad_idx, vecs[v].exp_kind);
            expect_ev(vecs[v].exp_kind, ops);
            send_header();
            if (vecs[v].bad_idx >= 0) begin
                send_payload(ops, 0, vecs[v].bad_idx - 1);
                send_byte(ops[127 - 8 * vecs[v].bad_idx -: 8], 1'b0);
            end else begin
                send_payload(ops, 0, 15);
                send_byte(vecs[v].chk, 1'b1);
            end
            drain($sformatf("vec%0d", v));
        end

        $display("[TB] resync: 00 BA BA CD + good payload");
        ops = {64'h0000000000000001, 64'h0000000000000002};
        expect_ev(EV_VALID, ops);
        send_byte(8'h00, 1'b1);
        send_byte(8'hBA, 1'b1);
        send_header();
        send_payload(ops, 0, 15);
        send_byte(8'hD0, 1'b1);
        drain("resync");

        $display("[TB] glitch: 6-cycle low pulse while in HDR1");
        ops = {64'hFFFFFFFFFFFFFFFF, 64'h0000000000000001};
        send_byte(8'hBA, 1'b1);
        check("glitch_busy_before", 128'(busy_o), 128'(1));
        @(negedge clk) rx = 1'b0;
        repeat (6) @(negedge clk);
        rx = 1'b1;
        idle_bits(3);
        check("glitch_busy_after", 128'(busy_o), 128'(1));
        expect_ev(EV_VALID, ops);
        send_byte(8'hCD, 1'b1);
        send_payload(ops, 0, 15);
        send_byte(8'hCD, 1'b1);
        drain("glitch");

        $display("[TB] reset after payload byte 9");
        ops = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210};
        send_header();
        send_payload(ops, 0, 8);
        pulse_reset();
        check("midreset_busy", 128'(busy_o), 128'(0));
        check("midreset_operands", operands_o, 128'h0);
        expect_ev(EV_VALID, ops);
        send_header();
        send_payload(ops, 0, 15);
        send_byte(8'hCC, 1'b1);
        drain("midreset");

        $display("[TB] 25-bit gap after payload byte 8");
        ops = {64'h1111111111111111, 64'h2222222222222222};
`ifndef PKT_TIMEOUT_EN
        expect_ev(EV_VALID, ops);
`endif
        send_header();
        send_payload(ops, 0, 7);
        idle_bits(25);
`ifdef PKT_TIMEOUT_EN
        check("gap_busy", 128'(busy_o), 128'(0));
`else
        check("gap_busy", 128'(busy_o), 128'(1));
`endif
        send_payload(ops, 8, 15);
        send_byte(8'h00, 1'b1);
        drain("gap");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_operand_rx.md
# uart_operand_rx

Receive-side front end for the adder top. Deserialises 8N1 UART bytes from the PC on `rx_i`, recognises the WRITE packet (header 0xBA 0xCD, 16 operand bytes, 1 checksum byte) and verifies the checksum. On a good packet it presents the two 64-bit operands to the adder stage with a one-cycle strobe. Bad packets produce error strobes that the transmit side turns into an ERROR reply.

## Interface
- `CLKS_PER_BIT`, 10416: clock cycles per UART bit (100 MHz / 9600).
- `TIMEOUT_CLKS`, 20*CLKS_PER_BIT: inter-byte gap that aborts a partial packet (used only with `PKT_TIMEOUT_EN`).
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rx_i`  in  1  asynchronous UART line, idle high.
- `operands_o`  out  128  {A[63:0], B[63:0]} of the last good packet.
- `operands_valid_o`  out  1  one-cycle pulse when `operands_o` updates.
- `chk_err_o`  out  1  one-cycle pulse on checksum mismatch.
- `frame_err_o`  out  1  one-cycle pulse when a stop bit samples 0.
- `busy_o`  out  1  high while the parser is past HDR0.

## Operation
- `rx_i` passes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized value.
- Byte FSM:
  - IDLE → START when the synced line is 0; bit counter cleared.
  - START: sample at count CLKS_PER_BIT/2−1. If 0 → DATA, else → IDLE (glitch rejected).
  - DATA: sample every CLKS_PER_BIT, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT. If 1 → internal byte strobe. If 0 → `frame_err_o`, byte dropped, parser forced to HDR0. Both outcomes → IDLE.
- Packet FSM (advances only on a byte strobe):
  - HDR0: 0xBA → HDR1; any other byte is dropped silently.
  - HDR1: 0xCD → PAYLOAD with count 0; 0xBA stays in HDR1; anything else → HDR0.
  - PAYLOAD: shift register `sr <= {sr[119:0], byte}`. After 16 bytes, the first byte received is at sr[127:120] (A MSB) and the last at sr[7:0] (B LSB) → CHK.
  - CHK: expected checksum = (0xCD + A[7:0] + B[7:0]) mod 256, i.e. (0xBACD + A + B) mod 256.
    - Match: `operands_o <= sr`, `operands_valid_o` pulses.
    - Mismatch: `chk_err_o` pulses, `operands_o` holds its previous value.
    - Either outcome → HDR0.
- Checksum arithmetic is 8-bit and wraps; carries are discarded.
- `operands_o` is a separate holding register. It changes only on a good packet and is stable between strobes.

## Timing
- Reset values: `operands_o`=0, `operands_valid_o`=0, `chk_err_o`=0, `frame_err_o`=0, `busy_o`=0. Byte FSM in IDLE, packet FSM in HDR0, all counters 0.
- Latency:
  - Line edge to synchronized value: 2 cycles.
  - Stop-bit sample to byte strobe: 1 cycle.
  - Byte strobe of the checksum byte to `operands_valid_o`/`chk_err_o`: 1 cycle.
- All strobes last exactly one cycle and are mutually exclusive.
- No backpressure. The consumer must take `operands_o` on the strobe, or later since the value holds.
- `rst_n` low in any cycle, including mid-byte or mid-packet, discards all partial state. Reception restarts with the next falling edge after release.
- A start edge arriving during STOP sampling is not lost: IDLE is entered in the cycle after the stop sample, and the start is detected from there.

## Configuration
- `PKT_TIMEOUT_EN` defined:
  - A gap counter clears on every byte strobe and counts while the packet FSM is not in HDR0.
  - Reaching TIMEOUT_CLKS forces HDR0 and drops the partial packet.
  - No error strobe is generated.
- `PKT_TIMEOUT_EN` undefined: no gap counter. A partial packet waits indefinitely for its remaining bytes.

## Test plan
Bench uses CLKS_PER_BIT=16.

1. Good packet: BA CD, A=0x0000000000000001, B=0x0000000000000002, checksum 0xD0 → `operands_o`=128'h0000000000000001_0000000000000002 and one `operands_valid_o` pulse.
2. Same packet with checksum 0xD1 → one `chk_err_o` pulse, no valid pulse, `operands_o` keeps its value from test 1.
3. Stop bit driven 0 on payload byte 5 → `frame_err_o` pulse, `busy_o` falls. A subsequent good packet (A=0xFF..FF, B=1, checksum 0xCD) → valid pulse with those operands.
4. Leading bytes 00 BA BA CD followed by a good payload → accepted (header resync); no error pulses.
5. Two cases:
   - Low pulse of 6 cycles on `rx_i` → no byte, no pulses.
   - `rst_n` low for 1 cycle after payload byte 9 → `busy_o`=0; the next full good packet is accepted.
6. Idle gap of 25 bit times after payload byte 8, then the remaining bytes:
   - With `PKT_TIMEOUT_EN`: no valid pulse, parser in HDR0.
   - Without it: valid pulse with the expected operands.
